gpio_timer_bank: RTL and testbench
==================================

GPIO_TIMER_BANK -- requirements
Module: gpio_timer_bank

Interface
REQ-001 Parameter NPORTS, default 3, number of GPIO ports (legal 1..3).
REQ-002 Parameter W, default 16, data width of io bus, ports and ticks counter.
REQ-003 Parameter PW, default 8, prescaler width (legal 1..8).
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 resetq  in  1  reset, synchronous, active-high (1 = reset).
REQ-006 io_rd  in  1  read strobe; reads have no side effects.
REQ-007 io_wr  in  1  write strobe.
REQ-008 io_addr  in  16  one-hot-style select; each set bit selects one register.
REQ-009 io_dout  in  W  write data from CPU.
REQ-010 io_din  out  W  read data to CPU, combinational.
REQ-011 pin_in  in  NPORTS*W  raw asynchronous pin inputs; port n at [n*W +: W].
REQ-012 pin_out  out  NPORTS*W  output register contents per port.
REQ-013 pin_oe  out  NPORTS*W  direction register per port (1 = drive).
REQ-014 irq  out  1  registered interrupt request, level.

Function
REQ-015 Port n register bits: 4n+0 IN (read synced pins), 4n+1 OUT (r/w), 4n+2 DIR (r/w), 4n+3 EDGE flags (read; write 1 clears bit).
REQ-016 Bit 14 TICKS: read counter; write loads counter from io_dout.
REQ-017 Bit 15 CTRL: bits [PW-1:0] prescale, [8] tick_irq_en, [9+n] port n irq_en; read returns CTRL with bit 15 = ovf_flag; write with io_dout[15]=1 also clears ovf_flag.
REQ-018 io_din SHALL be the bitwise OR of all selected registers; unselected/unused bits (12, 13, bits of absent ports) contribute 0.
REQ-019 Multiple select bits on one io_wr SHALL all take effect in the same cycle.
REQ-020 pin_in SHALL pass two synchroniser flops per bit; IN reads stage-2 value.
REQ-021 EDGE bit sets when stage-2 rises (previous 0, current 1) and DIR bit = 0; pin change at cycle t -> flag visible at t+3, irq at t+4.
REQ-022 Simultaneous edge-set and write-1-clear on the same bit: set wins.
REQ-023 Prescaler counts 0..prescale; ticks increments in the cycle prescaler equals prescale, prescaler then returns to 0; prescale 0 = increment every cycle.
REQ-024 ticks wraps all-ones -> 0 and sets ovf_flag on that increment.
REQ-025 TICKS write takes priority over increment, resets prescaler to 0, never sets ovf_flag.
REQ-026 ovf set and CTRL clear in same cycle: set wins.
REQ-027 irq next cycle = (ovf_flag & tick_irq_en) | OR over n of (|EDGE[n] & irq_en[n]).

Reset
REQ-028 resetq=1 SHALL clear OUT, DIR, EDGE, CTRL, ticks, prescaler, ovf_flag, synchroniser flops and irq to 0 on the next edge.
REQ-029 Reset mid-count or mid-edge discards all pending state; a pin held high through reset registers one rising edge 3 cycles after reset release.

Structure
REQ-030 Package gpio_timer_pkg holds address bit indices (IN/OUT/DIR/EDGE offsets, TICKS=14, CTRL=15) and CTRL field positions.
REQ-031 One sub-module gpio_port (OUT, DIR, synchroniser, edge flags, read mux) instantiated NPORTS times via generate.

Verification
REQ-032 Write 0x00A5 to addr 0x0002 and 0x00FF to 0x0004 -> pin_out[15:0]=0x00A5, pin_oe[15:0]=0x00FF; read 0x0006 -> io_din=0x00FF|0x00A5=0x00FF.
REQ-033 DIR=0, CTRL=0x0200, pin_in[0] 0->1 at cycle t -> EDGE0 bit0=1 at t+3, irq=1 at t+4; write 0x0001 to 0x0008 -> irq 0 one cycle later.
REQ-034 CTRL prescale=3, TICKS loaded 0xFFFE -> ticks 0xFFFF after 4 cycles, 0x0000 after 8 with ovf_flag=1; tick_irq_en=1 -> irq asserted.
REQ-035 TICKS write 0x1234 in same cycle as wrap -> ticks=0x1234, ovf_flag stays 0.
REQ-036 Edge on pin in same cycle as its write-1-clear -> flag remains 1; resetq pulse mid-count -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gpio_timer_pkg.sv
// Shared address map and CTRL field positions for the GPIO/timer register bank.
package gpio_timer_pkg;

    // Each GPIO port occupies four consecutive select bits in io_addr
    localparam int PORT_STRIDE = 4;
    localparam int OFS_IN      = 0;
    localparam int OFS_OUT     = 1;
    localparam int OFS_DIR     = 2;
    localparam int OFS_EDGE    = 3;

    localparam int ADDR_TICKS  = 14;
    localparam int ADDR_CTRL   = 15;

    localparam int CTRL_TICK_IRQ_EN = 8;
    localparam int CTRL_PORT_IRQ_EN = 9;
    localparam int CTRL_OVF         = 15;

    function automatic int port_sel_bit(input int port, input int ofs);
        return port * PORT_STRIDE + ofs;
    endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: OUT/DIR registers, two-flop pin synchroniser, rising-edge flags, read mux.
module gpio_port #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         wr_out,
    input  logic         wr_dir,
    input  logic         wr_edge,
    input  logic         rd_in,
    input  logic         rd_out,
    input  logic         rd_dir,
    input  logic         rd_edge,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] pin_out,
    output logic [W-1:0] pin_oe,
    output logic         edge_any,
    output logic [W-1:0] rdata
);

    logic [W-1:0] out_q, out_d;
    logic [W-1:0] dir_q, dir_d;
    logic [W-1:0] sync1_q, sync1_d;
    logic [W-1:0] sync2_q, sync2_d;
    logic [W-1:0] prev_q, prev_d;
    logic [W-1:0] edge_q, edge_d;
    logic [W-1:0] rise;

    always_comb begin
        out_d   = wr_out ? wdata : out_q;
        dir_d   = wr_dir ? wdata : dir_q;
        sync1_d = pin_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // Only input-direction bits flag edges
        rise    = sync2_q & ~prev_q & ~dir_q;
        edge_d  = edge_q;
        if (wr_edge) edge_d = edge_q & ~wdata;
        // A new edge in the same cycle as its clear must not be lost
        edge_d  = edge_d | rise;
        rdata   = ({W{rd_in}}   & sync2_q) |
                  ({W{rd_out}}  & out_q)   |
                  ({W{rd_dir}}  & dir_q)   |
                  ({W{rd_edge}} & edge_q);
    end

    always_ff @(posedge clk) begin
        if (resetq) begin
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign pin_out  = out_q;
    assign pin_oe   = dir_q;
    assign edge_any = |edge_q;

endmodule

// File: rtl/gpio_timer_bank.sv
// GPIO ports plus a prescaled free-running tick counter behind a one-hot select register bus.
module gpio_timer_bank
    import gpio_timer_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int W      = 16,
    parameter int PW     = 8
) (
    input  logic                clk,
    input  logic                resetq,
    input  logic                io_rd,
    input  logic                io_wr,
    input  logic [15:0]         io_addr,
    input  logic [W-1:0]        io_dout,
    output logic [W-1:0]        io_din,
    input  logic [NPORTS*W-1:0] pin_in,
    output logic [NPORTS*W-1:0] pin_out,
    output logic [NPORTS*W-1:0] pin_oe,
    output logic                irq
);

    // CTRL bit 15 is not storage; it reads back the overflow flag
    localparam logic [W-1:0] OVF_MASK = W'(1) << CTRL_OVF;

    logic [NPORTS-1:0][W-1:0] port_rdata;
    logic [NPORTS-1:0]        edge_any;

    for (genvar n = 0; n < NPORTS; n++) begin : g_port
        localparam int B = n * PORT_STRIDE;
        gpio_port #(.W(W)) u_port (
            .clk      (clk),
            .resetq   (resetq),
            .wr_out   (io_wr & io_addr[B + OFS_OUT]),
            .wr_dir   (io_wr & io_addr[B + OFS_DIR]),
            .wr_edge  (io_wr & io_addr[B + OFS_EDGE]),
            .rd_in    (io_addr[B + OFS_IN]),
            .rd_out   (io_addr[B + OFS_OUT]),
            .rd_dir   (io_addr[B + OFS_DIR]),
            .rd_edge  (io_addr[B + OFS_EDGE]),
            .wdata    (io_dout),
            .pin_in   (pin_in[n*W +: W]),
            .pin_out  (pin_out[n*W +: W]),
            .pin_oe   (pin_oe[n*W +: W]),
            .edge_any (edge_any[n]),
            .rdata    (port_rdata[n])
        );
    end

    // Select bits of absent ports and the reserved bits 12/13 decode to nothing
    logic [13-PORT_STRIDE*NPORTS:0] unused_addr;
    assign unused_addr = io_addr[13:PORT_STRIDE*NPORTS];

    logic [W-1:0]  ticks_q, ticks_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    logic          ctrl_wr, ticks_wr, ovf_set;
    logic [W-1:0]  ctrl_rd, rdata_all;

    always_comb begin
        ctrl_wr  = io_wr & io_addr[ADDR_CTRL];
        ticks_wr = io_wr & io_addr[ADDR_TICKS];
        ticks_d  = ticks_q;
        presc_d  = presc_q;
        ovf_set  = 1'b0;
        if (ticks_wr) begin
            ticks_d = io_dout;
            presc_d = '0;
        end else if (presc_q >= ctrl_q[PW-1:0]) begin
            // >= keeps the prescaler bounded if prescale is lowered mid-count
            presc_d = '0;
            ticks_d = ticks_q + W'(1);
            ovf_set = &ticks_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        ctrl_d = ctrl_wr ? (io_dout & ~OVF_MASK) : ctrl_q;
        ovf_d  = ovf_q;
        if (ctrl_wr && io_dout[CTRL_OVF]) ovf_d = 1'b0;
        if (ovf_set)                      ovf_d = 1'b1;

        irq_d = (ovf_q & ctrl_q[CTRL_TICK_IRQ_EN]) |
                (|(edge_any & ctrl_q[CTRL_PORT_IRQ_EN +: NPORTS]));

        ctrl_rd   = (ctrl_q & ~OVF_MASK) | (W'(ovf_q) << CTRL_OVF);
        rdata_all = '0;
        for (int n = 0; n < NPORTS; n++) rdata_all = rdata_all | port_rdata[n];
        if (io_addr[ADDR_TICKS]) rdata_all = rdata_all | ticks_q;
        if (io_addr[ADDR_CTRL])  rdata_all = rdata_all | ctrl_rd;
    end

    always_ff @(posedge clk) begin
        if (resetq) begin
            ticks_q <= '0;
            presc_q <= '0;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ticks_q <= ticks_d;
            presc_q <= presc_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    assign io_din = io_rd ? rdata_all : '0;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_timer_bank.sv
// Directed-vector bench for gpio_timer_bank with hand-computed expectations.
module tb_gpio_timer_bank;

    localparam int NPORTS = 3;
    localparam int W      = 16;
    localparam int PW     = 8;

    logic                clk     = 1'b0;
    logic                resetq  = 1'b1;
    logic                io_rd   = 1'b0;
    logic                io_wr   = 1'b0;
    logic [15:0]         io_addr = '0;
    logic [W-1:0]        io_dout = '0;
    logic [W-1:0]        io_din;
    logic [NPORTS*W-1:0] pin_in  = '0;
    logic [NPORTS*W-1:0] pin_out;
    logic [NPORTS*W-1:0] pin_oe;
    logic                irq;

    int vectors = 0;
    int errors  = 0;

    gpio_timer_bank #(.NPORTS(NPORTS), .W(W), .PW(PW)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_din  (io_din),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [W-1:0] data);
        io_addr = addr;
        io_dout = data;
        io_wr   = 1'b1;
        @(posedge clk);
        #1;
        io_wr   = 1'b0;
        io_addr = '0;
        io_dout = '0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [W-1:0] data);
        io_addr = addr;
        io_rd   = 1'b1;
        #1;
        data    = io_din;
        io_rd   = 1'b0;
        io_addr = '0;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        resetq = 1'b1;
        step(2);
        vectors++; if (pin_out !== '0) begin errors++; $display("FAIL reset_pin_out got %h want 0", pin_out); end
        vectors++; if (pin_oe !== '0) begin errors++; $display("FAIL reset_pin_oe got %h want 0", pin_oe); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        resetq = 1'b0;
        rd(16'h4000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_ticks got %h want 0000", d); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h want 0000", d); end
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_edge0 got %h want 0000", d); end
    endtask

    task automatic test_out_dir();
        logic [W-1:0] d;
        wr(16'h0002, 16'h00A5);
        wr(16'h0004, 16'h00FF);
        vectors++; if (pin_out[15:0] !== 16'h00A5) begin errors++; $display("FAIL out0 got %h want 00a5", pin_out[15:0]); end
        vectors++; if (pin_oe[15:0] !== 16'h00FF) begin errors++; $display("FAIL dir0 got %h want 00ff", pin_oe[15:0]); end
        rd(16'h0006, d);
        vectors++; if (d !== 16'h00FF) begin errors++; $display("FAIL rd_or_out_dir got %h want 00ff", d); end
        // Two selects in one write both land
        wr(16'h0060, 16'h0F0F);
        vectors++; if (pin_out[31:16] !== 16'h0F0F) begin errors++; $display("FAIL multi_out1 got %h want 0f0f", pin_out[31:16]); end
        vectors++; if (pin_oe[31:16] !== 16'h0F0F) begin errors++; $display("FAIL multi_dir1 got %h want 0f0f", pin_oe[31:16]); end
        rd(16'h0022, d);
        vectors++; if (d !== 16'h0FAF) begin errors++; $display("FAIL rd_or_ports got %h want 0faf", d); end
        rd(16'h3000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL rd_reserved got %h want 0000", d); end
        pin_in[47:32] = 16'hBEEF;
        step(1);
        rd(16'h0100, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL in2_1cyc got %h want 0000", d); end
        step(1);
        rd(16'h0100, d);
        vectors++; if (d !== 16'hBEEF) begin errors++; $display("FAIL in2_2cyc got %h want beef", d); end
    endtask

    task automatic test_edge();
        logic [W-1:0] d;
        wr(16'h0004, 16'h0000);
        wr(16'h8000, 16'h0200);
        wr(16'h0008, 16'hFFFF);
        pin_in[0] = 1'b1;
        step(2);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_t2 got %h want 0000", d); end
        step(1);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0001) begin errors++; $display("FAIL edge_t3 got %h want 0001", d); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_t3 got %b want 0", irq); end
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_t4 got %b want 1", irq); end
        wr(16'h0008, 16'h0001);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_clear got %h want 0000", d); end
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_clear_lag got %b want 1", irq); end
        step(1);
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b want 0", irq); end
        // Output-direction bits never flag edges
        wr(16'h0004, 16'h0002);
        pin_in[1] = 1'b1;
        step(4);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_dir_mask got %h want 0000", d); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_dir_mask got %b want 0", irq); end
    endtask

    task automatic test_edge_clear_race();
        logic [W-1:0] d;
        pin_in[2] = 1'b1;
        step(2);
        wr(16'h0008, 16'h0004);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0004) begin errors++; $display("FAIL edge_set_wins got %h want 0004", d); end
        wr(16'h0008, 16'h0004);
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL edge_race_clear got %h want 0000", d); end
        step(1);
    endtask

    task automatic test_ticks();
        logic [W-1:0] d;
        wr(16'h8000, 16'h0103);
        wr(16'h4000, 16'hFFFE);
        rd(16'h4000, d);
        vectors++; if (d !== 16'hFFFE) begin errors++; $display("FAIL ticks_load got %h want fffe", d); end
        step(3);
        rd(16'h4000, d);
        vectors++; if (d !== 16'hFFFE) begin errors++; $display("FAIL ticks_c3 got %h want fffe", d); end
        step(1);
        rd(16'h4000, d);
        vectors++; if (d !== 16'hFFFF) begin errors++; $display("FAIL ticks_c4 got %h want ffff", d); end
        step(3);
        rd(16'h4000, d);
        vectors++; if (d !== 16'hFFFF) begin errors++; $display("FAIL ticks_c7 got %h want ffff", d); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0103) begin errors++; $display("FAIL ctrl_c7 got %h want 0103", d); end
        step(1);
        rd(16'h4000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL ticks_wrap got %h want 0000", d); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h8103) begin errors++; $display("FAIL ovf_set got %h want 8103", d); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_lag got %b want 0", irq); end
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_ovf got %b want 1", irq); end
        wr(16'h8000, 16'h8103);
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0103) begin errors++; $display("FAIL ovf_clear got %h want 0103", d); end
        step(1);
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ovf_clear got %b want 0", irq); end
    endtask

    task automatic test_ticks_race();
        logic [W-1:0] d;
        wr(16'h8000, 16'h0100);
        wr(16'h4000, 16'hFFFF);
        wr(16'h4000, 16'h1234);
        rd(16'h4000, d);
        vectors++; if (d !== 16'h1234) begin errors++; $display("FAIL ticks_wr_wins got %h want 1234", d); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0100) begin errors++; $display("FAIL ticks_wr_no_ovf got %h want 0100", d); end
        step(1);
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_no_ovf got %b want 0", irq); end
        wr(16'h4000, 16'hFFFF);
        wr(16'h8000, 16'h8100);
        rd(16'h8000, d);
        vectors++; if (d !== 16'h8100) begin errors++; $display("FAIL ovf_set_wins got %h want 8100", d); end
        wr(16'h8000, 16'h0000);
        rd(16'h8000, d);
        vectors++; if (d !== 16'h8000) begin errors++; $display("FAIL ovf_keep got %h want 8000", d); end
        wr(16'h8000, 16'h8000);
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL ovf_clear2 got %h want 0000", d); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        wr(16'h8000, 16'h0703);
        wr(16'h4000, 16'h5555);
        resetq = 1'b1;
        step(1);
        vectors++; if (pin_out !== '0) begin errors++; $display("FAIL mid_reset_out got %h want 0", pin_out); end
        vectors++; if (pin_oe !== '0) begin errors++; $display("FAIL mid_reset_oe got %h want 0", pin_oe); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", irq); end
        rd(16'h4000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_reset_ticks got %h want 0000", d); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_reset_ctrl got %h want 0000", d); end
        resetq = 1'b0;
        step(2);
        rd(16'h0800, d);
        vectors++; if (d !== 16'h0000) begin errors++; $display("FAIL held_pin_c2 got %h want 0000", d); end
        step(1);
        rd(16'h0800, d);
        vectors++; if (d !== 16'hBEEF) begin errors++; $display("FAIL held_pin_c3 got %h want beef", d); end
        rd(16'h0008, d);
        vectors++; if (d !== 16'h0007) begin errors++; $display("FAIL held_pin0_c3 got %h want 0007", d); end
        rd(16'h0100, d);
        vectors++; if (d !== 16'hBEEF) begin errors++; $display("FAIL in2_after_reset got %h want beef", d); end
    endtask

    initial begin
        test_reset();
        test_out_dir();
        test_edge();
        test_edge_clear_race();
        test_ticks();
        test_ticks_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
